commit_ctrl: RTL
================

// Module: commit_ctrl
// PURPOSE
//  In-order retirement sequencer between ROB head and regfile/LSB. Pops one ready head entry per cycle max.
//  Drives regfile commit port (enable/rd/rob_pos/val) and completes stores via handshake with the LSB.
//  On mispredict, broadcasts the global clr flush and a PC redirect.
// PARAMETERS
//  DATA_W      32  commit value / PC width
//  REG_W       5   architectural register index width
//  ROB_POS_W   5   wrapped ROB tag width; tag 0 = "no producer"
//  FLUSH_HOLD  2   cycles after clr during which no commit occurs (>=1)
// PORTS
//  clk              in   1          clock
//  rst              in   1          async active-high reset
//  rdy              in   1          global ready; 0 freezes all state
//  head_valid       in   1          ROB head entry present
//  head_ready       in   1          head result computed
//  head_kind        in   2          0 REG, 1 STORE, 2 BRANCH, 3 NOP
//  head_rd          in   REG_W      destination register
//  head_rob_pos     in   ROB_POS_W  head tag
//  head_val         in   DATA_W     result value (link value for BRANCH)
//  head_mispredict  in   1          BRANCH mispredicted
//  head_target_pc   in   DATA_W     correct PC for redirect
//  rob_pop          out  1          pop ROB head this cycle
//  reg_we           out  1          regfile commit enable
//  reg_rd           out  REG_W      regfile commit rd
//  reg_rob_pos      out  ROB_POS_W  regfile commit tag
//  reg_val          out  DATA_W     regfile commit value
//  st_commit_req    out  1          ask LSB to perform head store
//  st_commit_ack    in   1          LSB store done
//  clr              out  1          global flush pulse
//  redirect_en      out  1          PC redirect valid
//  redirect_pc      out  DATA_W     redirect target
//  commit_cnt       out  32         retired-instruction counter
// BEHAVIOUR
//  Reset: all outputs 0, state RUN, hold counter 0, commit_cnt 0. All outputs registered.
//  rdy=0: state, counters and st_commit_req hold. One-cycle pulses (rob_pop, reg_we, clr, redirect_en) forced 0.
//  States: RUN, ST_WAIT, FLUSH.
//  RUN, head_valid&head_ready, by head_kind:
//   REG/NOP: next cycle rob_pop=1, commit_cnt+1. REG with rd!=0 also sets reg_we=1 with rd/rob_pos/val.
//    rd=0 never raises reg_we.
//   STORE: st_commit_req<=1 -> ST_WAIT; no pop yet.
//   BRANCH !mispredict: same as REG (link write if rd!=0).
//   BRANCH mispredict: rob_pop, optional reg_we (rd!=0), clr=1, redirect_en=1, redirect_pc=target, all in one cycle.
//    Then -> FLUSH with hold=FLUSH_HOLD.
//  RUN, head not valid/ready: no outputs; stay RUN.
//  ST_WAIT: st_commit_req stays 1 until st_commit_ack is sampled high.
//   Ack cycle: next cycle req=0, rob_pop=1, commit_cnt+1 -> RUN. Ack outside ST_WAIT is ignored.
//  FLUSH: head inputs ignored; hold decrements per rdy cycle; at 0 -> RUN.
//   clr and redirect_en are high only in the first cycle.
//  Max throughput 1 commit/cycle; REG latency 1 cycle from head ready to reg_we; store = 1 + ack latency + 1.
//  Back-to-back: head inputs reflect the post-pop head in the cycle after rob_pop; RUN may commit again immediately.
//  commit_cnt wraps modulo 2^32. reg_rob_pos equals head_rob_pos unchanged; the regfile does tag match.
//  Async rst mid-ST_WAIT or FLUSH: immediate return to reset values; the pending store is abandoned (LSB is reset too).
// STRUCTURE
//  Shared package/definition header: head_kind encodings, FSM state encodings.
//  Reuse existing DATA_TYPE, REG_POS_TYPE and ROB_WRAP_POS_TYPE macros.
//  Single module; no sub-module (FSM + hold counter + output regs).
// TESTING
//  1. REG rd=3 val=0x1234 tag=5 ready -> next cycle reg_we=1, rd=3, val=0x1234, pos=5, rob_pop=1, cnt=1.
//  2. REG rd=0 -> rob_pop=1, reg_we=0, cnt increments.
//  3. STORE, ack 3 cycles later -> req high 3 cycles; pop the cycle after ack; no reg_we.
//  4. BRANCH mispredict rd=1 target=0x100 -> one-cycle clr+redirect_pc=0x100+reg_we.
//     Next 2 cycles ignore a ready head; commits resume in cycle 4.
//  5. rdy=0 during ST_WAIT for 4 cycles -> req held, no pop; ack after rdy=1 completes normally.
//  6. rst pulse mid-FLUSH -> clr/redirect 0, state RUN, cnt 0; next ready REG commits normally.

Source files
------------

// File: rtl/commit_ctrl_pkg.sv
// rtl/commit_ctrl_pkg.sv - shared encodings for the commit sequencer
//
// Purpose: head_kind encodings and FSM state encodings used by commit_ctrl.
// Ports:   none (package).

package commit_ctrl_pkg;

   typedef enum logic [1:0] {
      KIND_REG    = 2'd0,
      KIND_STORE  = 2'd1,
      KIND_BRANCH = 2'd2,
      KIND_NOP    = 2'd3
   } head_kind_e;

   typedef enum logic [1:0] {
      S_RUN     = 2'd0,
      S_ST_WAIT = 2'd1,
      S_FLUSH   = 2'd2
   } state_e;

endpackage

// File: rtl/commit_ctrl.sv
// rtl/commit_ctrl.sv - in-order retirement sequencer between ROB head and regfile/LSB
//
// Purpose: retires at most one ready ROB head entry per cycle, writes the
//          regfile commit port, completes stores through a req/ack handshake
//          with the LSB, and on a mispredicted branch broadcasts clr plus a PC
//          redirect, then holds off commits for FLUSH_HOLD cycles.
// Ports:
//   clk, rst                 clock, async active-high reset
//   rdy                      global ready; 0 freezes all state
//   head_*                   ROB head entry (valid, ready, kind, rd, tag, value,
//                            mispredict flag, correct target PC)
//   rob_pop                  pop ROB head (pulse)
//   reg_we/rd/rob_pos/val    regfile commit port
//   st_commit_req/ack        store completion handshake with the LSB
//   clr, redirect_en/pc      flush pulse and PC redirect
//   commit_cnt               retired-instruction counter (wraps)

module commit_ctrl
   import commit_ctrl_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int REG_W      = 5,
   parameter int ROB_POS_W  = 5,
   parameter int FLUSH_HOLD = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rdy,
   input  logic                 head_valid,
   input  logic                 head_ready,
   input  logic [1:0]           head_kind,
   input  logic [REG_W-1:0]     head_rd,
   input  logic [ROB_POS_W-1:0] head_rob_pos,
   input  logic [DATA_W-1:0]    head_val,
   input  logic                 head_mispredict,
   input  logic [DATA_W-1:0]    head_target_pc,
   output logic                 rob_pop,
   output logic                 reg_we,
   output logic [REG_W-1:0]     reg_rd,
   output logic [ROB_POS_W-1:0] reg_rob_pos,
   output logic [DATA_W-1:0]    reg_val,
   output logic                 st_commit_req,
   input  logic                 st_commit_ack,
   output logic                 clr,
   output logic                 redirect_en,
   output logic [DATA_W-1:0]    redirect_pc,
   output logic [31:0]          commit_cnt
);

   localparam int HOLD_W = $clog2(FLUSH_HOLD + 1);

   state_e               state_q, state_d;
   logic [HOLD_W-1:0]    hold_q, hold_d;
   logic                 rob_pop_d, reg_we_d, req_d, clr_d, redir_d;
   logic [REG_W-1:0]     rd_d;
   logic [ROB_POS_W-1:0] pos_d;
   logic [DATA_W-1:0]    val_d, pc_d;
   logic [31:0]          cnt_d;
   head_kind_e           kind;

   assign kind = head_kind_e'(head_kind);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_RUN;
         hold_q        <= '0;
         rob_pop       <= 1'b0;
         reg_we        <= 1'b0;
         reg_rd        <= '0;
         reg_rob_pos   <= '0;
         reg_val       <= '0;
         st_commit_req <= 1'b0;
         clr           <= 1'b0;
         redirect_en   <= 1'b0;
         redirect_pc   <= '0;
         commit_cnt    <= '0;
      end else begin
         state_q       <= state_d;
         hold_q        <= hold_d;
         rob_pop       <= rob_pop_d;
         reg_we        <= reg_we_d;
         reg_rd        <= rd_d;
         reg_rob_pos   <= pos_d;
         reg_val       <= val_d;
         st_commit_req <= req_d;
         clr           <= clr_d;
         redirect_en   <= redir_d;
         redirect_pc   <= pc_d;
         commit_cnt    <= cnt_d;
      end
   end

   always_comb begin
      // Pulses default low; everything else holds, which also covers rdy=0.
      state_d   = state_q;
      hold_d    = hold_q;
      rob_pop_d = 1'b0;
      reg_we_d  = 1'b0;
      clr_d     = 1'b0;
      redir_d   = 1'b0;
      req_d     = st_commit_req;
      rd_d      = reg_rd;
      pos_d     = reg_rob_pos;
      val_d     = reg_val;
      pc_d      = redirect_pc;
      cnt_d     = commit_cnt;

      if (rdy) begin
         unique case (state_q)
            S_RUN: begin
               if (head_valid && head_ready) begin
                  if (kind == KIND_STORE) begin
                     req_d   = 1'b1;
                     state_d = S_ST_WAIT;
                  end else begin
                     rob_pop_d = 1'b1;
                     cnt_d     = commit_cnt + 32'd1;
                     // rd=0 is the hardwired zero register: never written.
                     if (kind != KIND_NOP && head_rd != '0) begin
                        reg_we_d = 1'b1;
                        rd_d     = head_rd;
                        pos_d    = head_rob_pos;
                        val_d    = head_val;
                     end
                     if (kind == KIND_BRANCH && head_mispredict) begin
                        clr_d   = 1'b1;
                        redir_d = 1'b1;
                        pc_d    = head_target_pc;
                        state_d = S_FLUSH;
                        hold_d  = HOLD_W'(FLUSH_HOLD);
                     end
                  end
               end
            end
            S_ST_WAIT: begin
               if (st_commit_ack) begin
                  req_d     = 1'b0;
                  rob_pop_d = 1'b1;
                  cnt_d     = commit_cnt + 32'd1;
                  state_d   = S_RUN;
               end
            end
            S_FLUSH: begin
               // Leaving on the last hold cycle gives exactly FLUSH_HOLD
               // sampling edges during which the head is ignored.
               if (hold_q <= HOLD_W'(1)) begin
                  hold_d  = '0;
                  state_d = S_RUN;
               end else begin
                  hold_d = hold_q - HOLD_W'(1);
               end
            end
            default: state_d = S_RUN;
         endcase
      end
   end

endmodule
